// File: rtl/cpubus_arbiter_2m_pkg.sv
// Shared types and constants for the two-master CPU bus arbiter.
//   arb_state_t         : arbiter FSM state encoding
//   ARB_ERR_DATA        : read data returned to a master on a watchdog timeout
//   ARB_TIMEOUT_DEFAULT : default number of BUSY cycles allowed before timeout
package cpubus_arbiter_2m_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam logic [31:0] ARB_ERR_DATA        = 32'hDEAD_BEEF;
  localparam int unsigned ARB_TIMEOUT_DEFAULT = 32'd255;

endpackage

// File: rtl/cpubus_arbiter_2m_bus_timeout_counter.sv
// Watchdog counter for the arbiter's BUSY phase.
//   clk_i     : system clock
//   reset_i   : asynchronous active-low reset
//   clear_i   : restart the count from zero (asserted at grant)
//   enable_i  : count one more waited cycle
//   expired_o : high while the count sits at TIMEOUT_CYCLES-1, i.e. the
//               current cycle is the last one the slave is allowed to take
module cpubus_arbiter_2m_bus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired_o = (cnt_q == CNT_LAST);

  // Next count: clear wins, otherwise count up and saturate at the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpubus_arbiter_2m.sv
// Two-master round-robin arbiter in front of a single memory-mapped slave.
// m0 is the core data port, m1 the UART debug bridge. One transaction is in
// flight at a time; the winning command is latched at grant and held on the
// s_* port until the slave acks or the watchdog expires, after which the
// granted master sees a one-cycle ack (plus err on timeout).
//   clk_i, reset_i (async, active low)
//   m{0,1}_req_i/we_i/addr_i/wdata_i : master commands
//   m{0,1}_rdata_o/ack_o/err_o       : registered master responses
//   s_req_o/we_o/addr_o/wdata_o      : registered slave command
//   s_rdata_i/s_ack_i                : slave response
module cpubus_arbiter_2m
  import cpubus_arbiter_2m_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic [DATA_W-1:0] s_rdata_i,
  input  logic              s_ack_i
);

  arb_state_t        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              s_req_q, s_req_d;
  logic              s_we_q, s_we_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
  logic              m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
  logic              m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

  logic              winner;
  logic              done_ack, done_err;
  logic [DATA_W-1:0] done_rdata;
  logic              cnt_clear, cnt_enable, cnt_expired;

  cpubus_arbiter_2m_bus_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (cnt_clear),
    .enable_i  (cnt_enable),
    .expired_o (cnt_expired)
  );

  // Next-state, grant and response computation.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    s_req_d      = s_req_q;
    s_we_d       = s_we_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    m0_ack_d     = 1'b0;
    m0_err_d     = 1'b0;
    m0_rdata_d   = {DATA_W{1'b0}};
    m1_ack_d     = 1'b0;
    m1_err_d     = 1'b0;
    m1_rdata_d   = {DATA_W{1'b0}};
    cnt_clear    = 1'b0;
    cnt_enable   = 1'b0;
    done_ack     = 1'b0;
    done_err     = 1'b0;
    done_rdata   = {DATA_W{1'b0}};

    // On contention the master that did not win last time goes next.
    if (m0_req_i && m1_req_i) begin
      winner = ~last_grant_q;
    end else begin
      winner = m1_req_i;
    end

    case (state_q)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          s_req_d      = 1'b1;
          s_we_d       = winner ? m1_we_i    : m0_we_i;
          s_addr_d     = winner ? m1_addr_i  : m0_addr_i;
          s_wdata_d    = winner ? m1_wdata_i : m0_wdata_i;
          last_grant_d = winner;
          cnt_clear    = 1'b1;
          state_d      = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // A slave ack in the final allowed cycle still counts as success.
        if (s_ack_i) begin
          s_req_d    = 1'b0;
          done_ack   = 1'b1;
          done_rdata = s_we_q ? {DATA_W{1'b0}} : s_rdata_i;
          state_d    = DONE;
        end else if (cnt_expired) begin
          s_req_d    = 1'b0;
          done_ack   = 1'b1;
          done_err   = 1'b1;
          done_rdata = DATA_W'(ARB_ERR_DATA);
          state_d    = DONE;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // last_grant_q names the owner of the transaction being completed.
    if (last_grant_q) begin
      m1_ack_d   = done_ack;
      m1_err_d   = done_err;
      m1_rdata_d = done_rdata;
    end else begin
      m0_ack_d   = done_ack;
      m0_err_d   = done_err;
      m0_rdata_d = done_rdata;
    end
  end

  // FSM state and all registered outputs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      s_req_q      <= 1'b0;
      s_we_q       <= 1'b0;
      s_addr_q     <= {ADDR_W{1'b0}};
      s_wdata_q    <= {DATA_W{1'b0}};
      m0_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m0_rdata_q   <= {DATA_W{1'b0}};
      m1_ack_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m1_rdata_q   <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      s_req_q      <= s_req_d;
      s_we_q       <= s_we_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      m0_ack_q     <= m0_ack_d;
      m0_err_q     <= m0_err_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_ack_q     <= m1_ack_d;
      m1_err_q     <= m1_err_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign s_req_o    = s_req_q;
  assign s_we_o     = s_we_q;
  assign s_addr_o   = s_addr_q;
  assign s_wdata_o  = s_wdata_q;
  assign m0_ack_o   = m0_ack_q;
  assign m0_err_o   = m0_err_q;
  assign m0_rdata_o = m0_rdata_q;
  assign m1_ack_o   = m1_ack_q;
  assign m1_err_o   = m1_err_q;
  assign m1_rdata_o = m1_rdata_q;

endmodule

// File: tb/tb_cpubus_arbiter_2m.sv
// Bench for cpubus_arbiter_2m (TIMEOUT_CYCLES=8). The reference model works
// per transaction: at grant it fixes the slave latency L, so the s_req window,
// the ack cycle, the error flag and the returned data follow by arithmetic.
module tb_cpubus_arbiter_2m;

  localparam int          T   = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_req_o, s_we_o, s_ack_i;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;

  always #5 clk = ~clk;

  cpubus_arbiter_2m #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // master stimulus state; mode 0 random, 1 release on ack, 2 re-request on ack
  logic        mreq [2];
  logic        mwe  [2];
  logic [31:0] maddr [2];
  logic [31:0] mwdata [2];
  int          mode = 1;
  int          force_lat = 0;
  bit          force_rd_en = 1'b0;
  logic [31:0] force_rd = 32'h0;
  int          stray_mode = 0;   // 0 none, 1 random, 2 every idle cycle
  bit          prev_rst = 1'b0;

  // current/last transaction record
  bit          tv = 1'b0;
  bit          last = 1'b1;
  int          t_owner, t_g, t_lat, t_end, t_ack;
  int          free_c = 0;
  bit          t_we, t_err;
  logic [31:0] t_addr, t_wdata, t_rd;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endfunction

  function automatic void compare_all();
    bit win, a0, a1;
    win = tv && (cyc > t_g) && (cyc <= t_end);
    a0  = tv && (cyc == t_ack) && (t_owner == 0);
    a1  = tv && (cyc == t_ack) && (t_owner == 1);
    chk("s_req", 64'(s_req_o), 64'(win));
    if (win) begin
      chk("s_we", 64'(s_we_o), 64'(t_we));
      chk("s_addr", 64'(s_addr_o), 64'(t_addr));
      chk("s_wdata", 64'(s_wdata_o), 64'(t_wdata));
    end
    chk("m0_ack", 64'(m0_ack_o), 64'(a0));
    chk("m0_err", 64'(m0_err_o), 64'(a0 && t_err));
    chk("m0_rdata", 64'(m0_rdata_o), a0 ? 64'(t_rd) : 64'h0);
    chk("m1_ack", 64'(m1_ack_o), 64'(a1));
    chk("m1_err", 64'(m1_err_o), 64'(a1 && t_err));
    chk("m1_rdata", 64'(m1_rdata_o), a1 ? 64'(t_rd) : 64'h0);
  endfunction

  task automatic newcmd(input int i);
    mwe[i]    = 1'($urandom);
    maddr[i]  = $urandom;
    mwdata[i] = $urandom;
  endtask

  task automatic apply();
    m0_req_i = mreq[0]; m0_we_i = mwe[0]; m0_addr_i = maddr[0]; m0_wdata_i = mwdata[0];
    m1_req_i = mreq[1]; m1_we_i = mwe[1]; m1_addr_i = maddr[1]; m1_wdata_i = mwdata[1];
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, "_s_req"}, 64'(s_req_o), 64'h0);
    chk({tag, "_s_we"}, 64'(s_we_o), 64'h0);
    chk({tag, "_s_addr"}, 64'(s_addr_o), 64'h0);
    chk({tag, "_s_wdata"}, 64'(s_wdata_o), 64'h0);
    chk({tag, "_acks"}, 64'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 64'h0);
    chk({tag, "_rdata"}, {m0_rdata_o, m1_rdata_o}, 64'h0);
  endtask

  // One clock cycle: check outputs of this cycle, then drive this cycle's inputs.
  task automatic step(input bit rst_val);
    int  w, r;
    bit  acknow, inwin;
    @(negedge clk);
    cyc++;
    compare_all();
    if (!rst_val) begin
      reset_i = 1'b0;
      tv = 1'b0; last = 1'b1;
      mreq[0] = 1'b0; mreq[1] = 1'b0;
      s_ack_i = 1'b0;
      apply();
      if (prev_rst) begin
        #1;
        zero_checks("async_rst");
      end
      prev_rst = 1'b0;
    end else begin
      reset_i = 1'b1;
      if (!prev_rst) free_c = cyc;
      prev_rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
        acknow = tv && (t_owner == i) && (cyc == t_ack);
        if (acknow) begin
          if (mode == 2) begin mreq[i] = 1'b1; newcmd(i); end
          else if (mode == 1) mreq[i] = 1'b0;
          else begin mreq[i] = 1'($urandom); newcmd(i); end
        end else if (mode == 0) begin
          if (tv && (t_owner == i) && (cyc > t_g) && (cyc < t_ack)) begin
            if ($urandom % 4 == 0) newcmd(i);
            if ($urandom % 8 == 0) mreq[i] = 1'b0;
          end else if (!mreq[i] && ($urandom % 3 == 0)) begin
            mreq[i] = 1'b1; newcmd(i);
          end
        end
      end
      apply();
      if ((cyc >= free_c) && (mreq[0] || mreq[1])) begin
        if (mreq[0] && mreq[1]) w = last ? 0 : 1;
        else w = mreq[1] ? 1 : 0;
        tv = 1'b1; t_owner = w; last = (w == 1); t_g = cyc;
        t_we = mwe[w]; t_addr = maddr[w]; t_wdata = mwdata[w];
        if (force_lat != 0) t_lat = force_lat;
        else begin
          r = $urandom % 8;
          t_lat = (r == 0) ? T + 1 : (r == 1) ? T : (r == 2) ? T - 1 : 1 + ($urandom % 3);
        end
        t_err = (t_lat > T);
        t_end = t_g + (t_err ? T : t_lat);
        t_ack = t_end + 1;
        free_c = t_ack + 1;
        t_rd = t_err ? ERR : 32'h0;
      end
      s_rdata_i = force_rd_en ? force_rd : $urandom;
      if (tv && !t_err && (cyc == t_g + t_lat)) begin
        s_ack_i = 1'b1;
        t_rd = t_we ? 32'h0 : s_rdata_i;
      end else begin
        inwin = tv && (cyc > t_g) && (cyc <= t_end);
        s_ack_i = !inwin && ((stray_mode == 2) || ((stray_mode == 1) && ($urandom % 3 == 0)));
      end
    end
  endtask

  task automatic run_until_ack(input int i, input int budget, output bit got, output bit err,
                               output logic [31:0] rd, output int nsreq);
    got = 1'b0; err = 1'b0; rd = 32'h0; nsreq = 0;
    for (int k = 0; k < budget && !got; k++) begin
      step(1'b1);
      if (s_req_o) nsreq++;
      if ((i == 0) ? m0_ack_o : m1_ack_o) begin
        got = 1'b1;
        err = (i == 0) ? m0_err_o : m1_err_o;
        rd  = (i == 0) ? m0_rdata_o : m1_rdata_o;
      end
    end
  endtask

  initial begin
    bit          got, err;
    logic [31:0] rd;
    int          ns, nack;
    int          order [$];
    int          exp_order [4];
    exp_order = '{0, 1, 0, 1};

    reset_i = 1'b0; s_ack_i = 1'b0; s_rdata_i = 32'h0;
    for (int i = 0; i < 2; i++) begin mreq[i] = 1'b0; mwe[i] = 1'b0; maddr[i] = 32'h0; mwdata[i] = 32'h0; end
    apply();
    for (int k = 0; k < 3; k++) step(1'b0);
    zero_checks("reset");
    step(1'b1);

    // m0 write 0x10/0xA5, slave ack in the second BUSY cycle; command edited mid-flight
    force_lat = 2;
    mreq[0] = 1'b1; mwe[0] = 1'b1; maddr[0] = 32'h10; mwdata[0] = 32'hA5;
    step(1'b1);
    step(1'b1);
    chk("w_c1_sreq", 64'(s_req_o), 64'h1);
    chk("w_c1_we", 64'(s_we_o), 64'h1);
    chk("w_c1_addr", 64'(s_addr_o), 64'h10);
    chk("w_c1_wdata", 64'(s_wdata_o), 64'hA5);
    maddr[0] = 32'h99; mwdata[0] = 32'h0;
    step(1'b1);
    chk("w_c2_sreq", 64'(s_req_o), 64'h1);
    chk("w_c2_addr_held", 64'(s_addr_o), 64'h10);
    step(1'b1);
    chk("w_c3_m0_ack", 64'({m0_ack_o, m0_err_o}), 64'h2);
    chk("w_c3_m1_quiet", 64'({m1_ack_o, m1_err_o}), 64'h0);
    step(1'b1);
    chk("w_c4_sreq", 64'(s_req_o), 64'h0);

    // m1 read 0x20, slave acks in the first BUSY cycle; m1 drops req after grant
    force_lat = 1; force_rd_en = 1'b1; force_rd = 32'h1234_5678;
    mreq[1] = 1'b1; mwe[1] = 1'b0; maddr[1] = 32'h20; mwdata[1] = 32'h0;
    step(1'b1);
    mreq[1] = 1'b0;
    step(1'b1);
    chk("r_c1_addr", 64'(s_addr_o), 64'h20);
    chk("r_c1_we", 64'(s_we_o), 64'h0);
    step(1'b1);
    chk("r_c2_m1_ack", 64'(m1_ack_o), 64'h1);
    chk("r_c2_m1_rdata", 64'(m1_rdata_o), 64'h1234_5678);
    chk("r_c2_m0_quiet", 64'({m0_ack_o, m0_rdata_o}), 64'h0);
    force_rd_en = 1'b0;

    // both masters keep requesting: grants must alternate starting with m0
    mode = 2;
    mreq[0] = 1'b1; newcmd(0); mreq[1] = 1'b1; newcmd(1);
    for (int k = 0; k < 40 && order.size() < 4; k++) begin
      step(1'b1);
      if (m0_ack_o) order.push_back(0);
      if (m1_ack_o) order.push_back(1);
    end
    chk("fair_count", 64'(order.size()), 64'h4);
    for (int k = 0; k < 4 && k < order.size(); k++) chk("fair_order", 64'(order[k]), 64'(exp_order[k]));
    mode = 1; mreq[0] = 1'b0; mreq[1] = 1'b0;
    for (int k = 0; k < 4; k++) step(1'b1);

    // slave never answers: exactly T request cycles, then err with ERR data
    force_lat = T + 1;
    mreq[0] = 1'b1; mwe[0] = 1'b0; maddr[0] = 32'h30;
    run_until_ack(0, 20, got, err, rd, ns);
    chk("to_ack", 64'(got), 64'h1);
    chk("to_sreq_cycles", 64'(ns), 64'(T));
    chk("to_err", 64'(err), 64'h1);
    chk("to_rdata", 64'(rd), 64'hDEAD_BEEF);
    force_lat = 1;
    mreq[0] = 1'b1; mwe[0] = 1'b1; maddr[0] = 32'h34; mwdata[0] = 32'h5;
    run_until_ack(0, 10, got, err, rd, ns);
    chk("after_to_ack", 64'({got, err}), 64'h2);

    // ack in the last allowed BUSY cycle wins over the timeout
    force_lat = T; force_rd_en = 1'b1; force_rd = 32'hCAFE_F00D;
    mreq[1] = 1'b1; mwe[1] = 1'b0; maddr[1] = 32'h40;
    run_until_ack(1, 20, got, err, rd, ns);
    chk("edge_ack", 64'({got, err}), 64'h2);
    chk("edge_sreq_cycles", 64'(ns), 64'(T));
    chk("edge_rdata", 64'(rd), 64'hCAFE_F00D);
    force_rd_en = 1'b0;

    // reset pulse while BUSY, stray slave acks afterwards, then a fresh request
    force_lat = T + 1;
    mreq[1] = 1'b1; mwe[1] = 1'b0; maddr[1] = 32'h50;
    for (int k = 0; k < 4; k++) step(1'b1);
    step(1'b0);
    stray_mode = 2;
    nack = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1);
      if (m0_ack_o || m1_ack_o || s_req_o) nack++;
    end
    chk("no_activity_after_rst", 64'(nack), 64'h0);
    force_lat = 2;
    mreq[0] = 1'b1; mwe[0] = 1'b1; maddr[0] = 32'h60; mwdata[0] = 32'h7;
    run_until_ack(0, 10, got, err, rd, ns);
    chk("post_rst_ack", 64'({got, err}), 64'h2);
    chk("post_rst_sreq_cycles", 64'(ns), 64'h2);

    // randomized traffic, with one reset in the middle
    mode = 0; force_lat = 0; stray_mode = 1;
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) step(1'b0);
      else step(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
